vect_exec: RTL
==============

# vect_exec

Vector execute stage of the ASIP pipeline. It sits directly downstream of the vector pipeline register and consumes its opcode and two operand vectors. It performs lane-wise ALU operations: single-cycle for logic, add, sub and shift, and lane-sequential for multiply. During a multiply it back-pressures the upstream register with `stall`. It produces a registered result vector with a one-cycle `valid_out` strobe for the writeback stage.

## Interface
- `registerSize`, 8, bit width of one vector lane
- `vectorSize`, 4, number of lanes
- `WIDTH`, 8, width of the control word carried by the upstream register; opcode is `ctrl[2:0]`, remaining bits ignored
- `clk`  in  1  clock; all state changes on rising edge
- `reset`  in  1  synchronous, active-high; sampled on rising edge of `clk`
- `valid_in`  in  1  upstream register holds a valid instruction
- `ctrl`  in  WIDTH  control word from the upstream register
- `vect1`, `vect2`  in  [vectorSize-1:0][registerSize-1:0]  operand vectors; lane i = `vectX[i]`
- `stall`  out  1  combinational; upstream register must hold its contents while high
- `valid_out`  out  1  registered; `result` valid this cycle, one-cycle pulse per instruction
- `result`  out  [vectorSize-1:0][registerSize-1:0]  registered result vector

## Operation
- Opcodes; all arithmetic is per lane, modulo 2^registerSize, no carries between lanes:
  - 000 ADD
  - 001 SUB (vect1 − vect2)
  - 010 AND
  - 011 OR
  - 100 XOR
  - 101 MUL: low registerSize bits of the product
  - 110 SLL: vect1 shifted left by the full unsigned value of vect2 lane; result 0 if the amount ≥ registerSize
  - 111 PASS: result = vect1
- FSM states:
  - IDLE (reset state): instructions are accepted here.
  - MUL: holds latched operands and lane counter `k` (0..vectorSize-1).
- IDLE, `valid_in`=1, op≠MUL: compute all lanes, load `result`, set `valid_out`=1 next cycle, stay in IDLE.
- IDLE, `valid_in`=1, op=MUL:
  - Latch `vect1`/`vect2` into operand registers.
  - Set `k`=0 and go to MUL.
  - `result` is not changed.
- MUL state:
  - Each cycle, compute lane `k` into an internal accumulator and increment `k`.
  - When `k`=vectorSize-1, copy the accumulator (with the final lane) into `result`, set `valid_out`=1 next cycle and go to IDLE.
  - `valid_in` and the operand inputs are ignored in MUL.
- `valid_in`=0 in IDLE: no state change; `valid_out`=0 next cycle; `result` holds.
- `result` holds its last value whenever `valid_out`=0.

## Timing
- Reset values: `result`=0, `valid_out`=0, state IDLE, `k`=0, accumulator and operand registers 0. `stall`=0 while `reset`=1.
- Single-cycle op accepted at edge-cycle T gives `valid_out`=1 in T+1. Throughput is one instruction per cycle, so back-to-back ops give back-to-back `valid_out`.
- `stall` = (IDLE ∧ `valid_in` ∧ op=MUL) ∨ (MUL ∧ k≠vectorSize-1).
- MUL accepted in cycle T:
  - `stall`=1 in T..T+vectorSize-1 and 0 in T+vectorSize (the last-lane cycle).
  - The upstream register advances on the edge ending T+vectorSize.
  - `valid_out`=1 in T+vectorSize+1, which is also the first cycle the next instruction can be accepted.
- Reset asserted in any cycle, including mid-MUL:
  - Next cycle: IDLE, `valid_out`=0, `result`=0.
  - The pending MUL is discarded and never produces `valid_out`.
- vectorSize=1: MUL has `stall`=1 only in the accept cycle and `valid_out` at T+2.

## Test plan
Default parameters; lanes listed lane0..lane3.
- Reset: hold `reset` 2 cycles with `valid_in`=1, op=MUL → `stall`=0, `valid_out`=0, `result`=0 throughout; first post-reset cycle accepts normally.
- ADD {FF,10,01,80}+{01,20,01,80} → `valid_out`=1 next cycle, `result`={00,30,02,00}. Same operands with SUB → {FE,F0,00,00}.
- Back-to-back: XOR {AA,..}^{FF,..} then PASS {12,34,56,78} on consecutive cycles → `valid_out` high two consecutive cycles, lane0=55 then `result`={12,34,56,78}; `stall` never high.
- MUL {03,10,FF,07}×{05,10,02,00} at T → `stall`=1 at T..T+3, 0 at T+4; `valid_out`=1 only at T+5 with `result`={0F,00,FE,00}. An ADD presented at T+5 gives `valid_out` at T+6.
- SLL {01,01,01,01} by {00,07,08,C8} → {01,80,00,00}.
- Reset at T+2 of a MUL → at T+3 `stall`=0, `valid_out`=0, `result`=0; no `valid_out` for the aborted MUL; the next ADD completes normally.

Source files
------------

// File: rtl/vect_exec_if.sv
// Upstream pipeline-register to vector execute stage bus: operands in, stall/result back.
interface vect_exec_if #(
    parameter int unsigned registerSize = 8,
    parameter int unsigned vectorSize   = 4,
    parameter int unsigned WIDTH        = 8
);
    logic                                       valid_in;
    logic [WIDTH-1:0]                           ctrl;
    logic [vectorSize-1:0][registerSize-1:0]    vect1;
    logic [vectorSize-1:0][registerSize-1:0]    vect2;
    logic                                       stall;
    logic                                       valid_out;
    logic [vectorSize-1:0][registerSize-1:0]    result;

    modport master (
        output valid_in, ctrl, vect1, vect2,
        input  stall, valid_out, result
    );

    modport slave (
        input  valid_in, ctrl, vect1, vect2,
        output stall, valid_out, result
    );
endinterface

// File: rtl/vect_exec.sv
// Vector execute stage: single-cycle lane-wise ALU ops, lane-sequential multiply
// with upstream back-pressure, registered result plus one-cycle valid strobe.
module vect_exec #(
    parameter int unsigned registerSize = 8,
    parameter int unsigned vectorSize   = 4,
    parameter int unsigned WIDTH        = 8
) (
    input  logic        clk,
    input  logic        reset,
    vect_exec_if.slave  bus
);
    localparam int unsigned KW = (vectorSize > 1) ? $clog2(vectorSize) : 1;
    localparam logic [KW-1:0] KMAX = KW'(vectorSize - 1);
    localparam logic [2:0] OP_MUL = 3'd5;

    typedef logic [vectorSize-1:0][registerSize-1:0] vec_t;
    typedef enum logic {S_IDLE, S_MUL} state_t;

    state_t          state;
    logic [KW-1:0]   k;
    vec_t            opa, opb, acc, result_q;
    logic            valid_q;
    vec_t            alu_vec, mul_acc;
    logic [2:0]      op;

    assign op = bus.ctrl[2:0];

    // Upper control bits belong to other pipeline stages.
    logic ctrl_unused;
    assign ctrl_unused = ^bus.ctrl;

    function automatic logic [registerSize-1:0] lane_op(
        input logic [2:0]              f,
        input logic [registerSize-1:0] a,
        input logic [registerSize-1:0] b
    );
        case (f)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            3'd5:    return a * b;
            3'd6:    return (32'(b) >= registerSize) ? '0 : (a << b);
            default: return a;
        endcase
    endfunction

    always_comb begin
        alu_vec = '0;
        for (int i = 0; i < int'(vectorSize); i++)
            alu_vec[i] = lane_op(op, bus.vect1[i], bus.vect2[i]);
    end

    // Accumulator with the current lane's product merged in.
    always_comb begin
        mul_acc    = acc;
        mul_acc[k] = lane_op(OP_MUL, opa[k], opb[k]);
    end

    assign bus.stall = !reset &&
                       (((state == S_IDLE) && bus.valid_in && (op == OP_MUL)) ||
                        ((state == S_MUL) && (k != KMAX)));
    assign bus.valid_out = valid_q;
    assign bus.result    = result_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            k        <= '0;
            opa      <= '0;
            opb      <= '0;
            acc      <= '0;
            result_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.valid_in) begin
                        if (op == OP_MUL) begin
                            opa   <= bus.vect1;
                            opb   <= bus.vect2;
                            k     <= '0;
                            state <= S_MUL;
                        end else begin
                            result_q <= alu_vec;
                            valid_q  <= 1'b1;
                        end
                    end
                end
                S_MUL: begin
                    acc <= mul_acc;
                    if (k == KMAX) begin
                        result_q <= mul_acc;
                        valid_q  <= 1'b1;
                        k        <= '0;
                        state    <= S_IDLE;
                    end else begin
                        k <= k + KW'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
